// File: rtl/tt_mux_pg_if.sv
// Spine and user-module buses of one power-gated row-mux branch.
// slave is the mux side; master is the spine / user-module side.
interface tt_mux_pg_if #(
   parameter int N_UM = 16,
   parameter int N_IO = 8,
   parameter int N_O  = 8,
   parameter int N_I  = 10
);
   localparam int U_OW = N_O + 2 * N_IO;
   localparam int U_IW = N_I + N_IO;
   localparam int S_OW = U_OW + 2;
   localparam int S_IW = U_IW + 12;

   logic [U_OW*N_UM-1:0] um_ow;
   logic [U_IW*N_UM-1:0] um_iw;
   logic [N_UM-1:0]      um_ena;
   logic [N_UM-1:0]      um_pg_ena;
   logic [N_UM-1:0]      um_k_zero;
   logic [S_OW-1:0]      spine_ow;
   logic [S_IW-1:0]      spine_iw;

   modport slave (
      input  um_ow,
      input  spine_iw,
      output um_iw,
      output um_ena,
      output um_pg_ena,
      output um_k_zero,
      output spine_ow
   );

   modport master (
      output um_ow,
      output spine_iw,
      input  um_iw,
      input  um_ena,
      input  um_pg_ena,
      input  um_k_zero,
      input  spine_ow
   );
endinterface

// File: rtl/tt_mux_pg.sv
// Power-gated row mux: decodes the spine select, sequences power-up,
// enable, isolation and power-down of one user module at a time.
module tt_mux_pg #(
   parameter int N_UM    = 16,
   parameter int N_IO    = 8,
   parameter int N_O     = 8,
   parameter int N_I     = 10,
   parameter int PG_DLY  = 8,
   parameter int DIS_DLY = 2
) (
   input  logic              clk,
   input  logic              rst,
   tt_mux_pg_if.slave        bus,
   input  logic [3:0]        addr,
   output logic              busy,
   output logic              k_zero,
   output logic              k_one
);
   localparam int U_OW = N_O + 2 * N_IO;
   localparam int U_IW = N_I + N_IO;
   localparam int S_IW = U_IW + 12;

   localparam logic [5:0] NUM6     = 6'(N_UM);
   localparam logic [7:0] PG_LAST  = 8'(PG_DLY - 1);
   localparam logic [7:0] DIS_LAST = 8'(DIS_DLY - 1);

   typedef enum logic [1:0] {
      IDLE,
      PWR_UP,
      ACTIVE,
      PWR_DN
   } state_t;

   logic            si_ena;
   logic [8:0]      si_sel;
   logic [U_IW-1:0] si_usr;
   logic            unused_guard;

   assign si_ena = bus.spine_iw[1];
   assign si_sel = bus.spine_iw[10:2];
   assign si_usr = bus.spine_iw[11 +: U_IW];
   // Spine guard bits carry no information.
   assign unused_guard = ^{bus.spine_iw[0], bus.spine_iw[S_IW-1]};

   logic                 req_v_q, req_v_d;
   logic [4:0]           req_t_q, req_t_d;
   state_t               state_q, state_d;
   logic [4:0]           cur_q, cur_d;
   logic [7:0]           cnt_q, cnt_d;
   logic [N_UM-1:0]      ena_q, ena_d;
   logic [N_UM-1:0]      pg_q, pg_d;
   logic [U_IW*N_UM-1:0] iw_q, iw_d;
   logic [U_OW-1:0]      so_q, so_d;
   logic                 busy_q, busy_d;

   always_comb begin
      req_t_d = si_sel[4:0];
      req_v_d = si_ena
             && (si_sel[8:5] == addr)
             && ({1'b0, si_sel[4:0]} < NUM6);
   end

   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (req_v_q) begin
               state_d = PWR_UP;
               cur_d   = req_t_q;
               cnt_d   = '0;
            end
         end
         PWR_UP: begin
            if (!req_v_q) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (req_t_q != cur_q) begin
               cur_d = req_t_q;
               cnt_d = '0;
            end else if (cnt_q == PG_LAST) begin
               state_d = ACTIVE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ACTIVE: begin
            if (!req_v_q || (req_t_q != cur_q)) begin
               state_d = PWR_DN;
               cnt_d   = '0;
            end
         end
         PWR_DN: begin
            // Pending requests wait until the hold time has elapsed.
            if (cnt_q == DIS_LAST) begin
               cnt_d = '0;
               if (req_v_q) begin
                  state_d = PWR_UP;
                  cur_d   = req_t_q;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      pg_d   = '0;
      ena_d  = '0;
      iw_d   = '0;
      so_d   = '0;
      busy_d = (state_d == PWR_UP) || (state_d == PWR_DN);
      for (int i = 0; i < N_UM; i++) begin
         if (cur_d == 5'(i)) begin
            pg_d[i]  = (state_d != IDLE);
            ena_d[i] = (state_d == ACTIVE);
            if (state_d == ACTIVE) begin
               iw_d[U_IW*i +: U_IW] = si_usr;
            end
         end
         // Outward data only while the module stays enabled.
         if ((cur_q == 5'(i)) && (state_q == ACTIVE)
             && (state_d == ACTIVE)) begin
            so_d = bus.um_ow[U_OW*i +: U_OW];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_v_q <= 1'b0;
         req_t_q <= '0;
         state_q <= IDLE;
         cur_q   <= '0;
         cnt_q   <= '0;
         ena_q   <= '0;
         pg_q    <= '0;
         iw_q    <= '0;
         so_q    <= '0;
         busy_q  <= 1'b0;
      end else begin
         req_v_q <= req_v_d;
         req_t_q <= req_t_d;
         state_q <= state_d;
         cur_q   <= cur_d;
         cnt_q   <= cnt_d;
         ena_q   <= ena_d;
         pg_q    <= pg_d;
         iw_q    <= iw_d;
         so_q    <= so_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.um_ena    = ena_q;
   assign bus.um_pg_ena = pg_q;
   assign bus.um_iw     = iw_q;
   assign bus.um_k_zero = '0;
   assign bus.spine_ow  = {1'b0, so_q, 1'b0};
   assign busy          = busy_q;
   assign k_zero        = 1'b0;
   assign k_one         = 1'b1;
endmodule
